// File: rtl/row_drain.sv
// row_drain: buffers wide result rows and drains them one word per handshake.
//
// Purpose
//   Sits directly after the PE result write stage. Each row_we strobe
//   delivers one full row of ARRAY_SIZE words plus a small tag. Up to
//   ROW_DEPTH rows are held in a circular buffer. The head row is then
//   serialized word by word onto a valid/ready stream for the host/DMA.
//
// Parameters
//   ARRAY_SIZE : words per row (power of 2, >= 2)
//   DATA_WIDTH : bits per word
//   ROW_DEPTH  : row buffer entries (power of 2, >= 2)
//
// Ports
//   clk, srst      : clock and synchronous active-high reset
//   row_we         : row write strobe
//   row_wdata      : row payload, word i = [i*DATA_WIDTH +: DATA_WIDTH]
//   row_waddr      : row tag, stored with the row
//   row_full       : buffer holds ROW_DEPTH rows
//   out_valid      : out_* carry a valid word
//   out_ready      : consumer accepts the word
//   out_data       : current word
//   out_idx        : word index within the row
//   out_tag        : tag of the row being drained
//   out_last       : current word is the last of its row
//   out_parity     : XOR-reduce of out_data (ROW_DRAIN_PARITY_EN only)
//   overflow       : sticky flag, a row write was dropped
//   busy           : buffer non-empty
//
// Build option
//   ROW_DRAIN_PARITY_EN : adds per-word parity storage and out_parity.

module row_drain #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROW_DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             row_we,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_wdata,
    input  logic [$clog2(ARRAY_SIZE)-1:0]    row_waddr,
    output logic                             row_full,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(ARRAY_SIZE)-1:0]    out_idx,
    output logic [$clog2(ARRAY_SIZE)-1:0]    out_tag,
    output logic                             out_last,
`ifdef ROW_DRAIN_PARITY_EN
    output logic                             out_parity,
`endif
    output logic                             overflow,
    output logic                             busy
);

    localparam int IW = $clog2(ARRAY_SIZE);
    localparam int PW = $clog2(ROW_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = ARRAY_SIZE * DATA_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   word_cnt_q, word_cnt_d;
    logic            overflow_q, overflow_d;

    // Row storage: deliberately not reset, the pointers define validity.
    logic [RW-1:0]   row_mem_q [ROW_DEPTH];
    logic [IW-1:0]   tag_mem_q [ROW_DEPTH];

`ifdef ROW_DRAIN_PARITY_EN
    logic [ARRAY_SIZE-1:0] par_mem_q [ROW_DEPTH];
    logic [ARRAY_SIZE-1:0] wr_par;
    logic                  head_par;
`endif

    // ------------------------------------------------------------------
    // Handshake and buffer events
    // ------------------------------------------------------------------
    logic            draining;
    logic            full;
    logic            last_word;
    logic            xfer;
    logic            pop;
    logic            accept;

    always_comb begin
        draining  = (state_q == S_DRAIN);
        full      = (count_q == CW'(ROW_DEPTH));
        last_word = (word_cnt_q == IW'(ARRAY_SIZE - 1));
        xfer      = draining & out_ready;
        pop       = xfer & last_word;
        // A write into a full buffer still lands when the head row is
        // leaving on this very edge: its slot is the one wr_ptr points at.
        accept    = row_we & (~full | pop);
    end

    // ------------------------------------------------------------------
    // Drain FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && !accept && (count_q == CW'(1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointer, counter and flag next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        // word_cnt wraps to 0 on its own after the last word since
        // ARRAY_SIZE is a power of two.
        if (xfer) begin
            word_cnt_d = word_cnt_q + IW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (row_we && !accept) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Row storage
    // ------------------------------------------------------------------
`ifdef ROW_DRAIN_PARITY_EN
    // Parity is taken once at accept time so the read side only muxes.
    always_comb begin
        wr_par = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            wr_par[i] = ^row_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (accept && !srst) begin
            row_mem_q[wr_ptr_q] <= row_wdata;
            tag_mem_q[wr_ptr_q] <= row_waddr;
`ifdef ROW_DRAIN_PARITY_EN
            par_mem_q[wr_ptr_q] <= wr_par;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read side: select the current word of the head row
    // ------------------------------------------------------------------
    logic [RW-1:0]         head_row;
    logic [DATA_WIDTH-1:0] head_word;

    always_comb begin
        head_row  = row_mem_q[rd_ptr_q];
        head_word = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (word_cnt_q == IW'(i)) begin
                head_word = head_row[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef ROW_DRAIN_PARITY_EN
    always_comb begin
        head_par = par_mem_q[rd_ptr_q][word_cnt_q];
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: everything is registered state, so out_* hold by
    // themselves under back-pressure and are forced to 0 when idle.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = draining;
        out_data  = '0;
        out_idx   = '0;
        out_tag   = '0;
        out_last  = 1'b0;
        if (draining) begin
            out_data = head_word;
            out_idx  = word_cnt_q;
            out_tag  = tag_mem_q[rd_ptr_q];
            out_last = last_word;
        end
        row_full = full;
        busy     = (count_q != '0);
        overflow = overflow_q;
    end

`ifdef ROW_DRAIN_PARITY_EN
    always_comb begin
        out_parity = draining & head_par;
    end
`endif

endmodule

// File: doc/row_drain.md
Name: row_drain

Overview:
- Consumes the wide result-row write produced by the PE output write stage: one `ARRAY_SIZE*DATA_WIDTH` row per write strobe.
- Buffers up to `ROW_DEPTH` rows and serializes each row into `ARRAY_SIZE` single-precision words.
- Presents the words on a valid/ready stream towards the host/DMA side.
- Sits directly downstream of the result write stage, in place of (or alongside) the result SRAM.

Parameters:
- `ARRAY_SIZE`, 32, words per row (power of 2, ≥2).
- `DATA_WIDTH`, 32, bits per word (single-precision float).
- `ROW_DEPTH`, 2, row buffer entries (power of 2, ≥2).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `srst`  in  1  synchronous reset, active-high.
- `row_we`  in  1  row write strobe from the result write stage.
- `row_wdata`  in  `ARRAY_SIZE*DATA_WIDTH`  row data; word i = bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `row_waddr`  in  `$clog2(ARRAY_SIZE)`  row tag, stored with the row.
- `row_full`  out  1  buffer holds `ROW_DEPTH` rows.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts word.
- `out_data`  out  `DATA_WIDTH`  current word.
- `out_idx`  out  `$clog2(ARRAY_SIZE)`  word index within row.
- `out_tag`  out  `$clog2(ARRAY_SIZE)`  tag of row being drained.
- `out_last`  out  1  current word is index `ARRAY_SIZE-1`.
- `overflow`  out  1  sticky: a row write was dropped.
- `busy`  out  1  buffer non-empty.

Behaviour:
- **Reset (`srst`=1 at clock edge):**
  - `wr_ptr`, `rd_ptr`, `count`, `word_cnt` ← 0; `overflow` ← 0.
  - Outputs: `out_valid`=0, `row_full`=0, `busy`=0, `out_data`/`out_idx`/`out_tag`/`out_last`=0.
  - Row storage contents are not reset.
  - Reset mid-drain discards all buffered rows and the partial row.
  - `srst` has priority over every other event in the same cycle.
- **Transfer:** `xfer` = `out_valid & out_ready`.
- **Pop:** `pop` = `xfer & (word_cnt == ARRAY_SIZE-1)`.
- **Write acceptance:**
  - `row_we` is accepted when `count < ROW_DEPTH`, or when `pop` occurs in the same cycle (write-through-full).
  - Accepted: row and tag stored at `wr_ptr`; `wr_ptr` advances, wrapping modulo `ROW_DEPTH`.
  - Rejected (full and no pop): data dropped, `overflow` ← 1 and held until reset.
- **Count update:** `count` += accept − pop; a simultaneous accept and pop leaves `count` unchanged.
- **Latency:** a row accepted at edge N gives `out_valid`=1 from cycle N+1 (when the buffer was empty); no combinational path from `row_we` to `out_*`.
- **Drain FSM:**
  - States:
    - IDLE: `count`==0.
    - DRAIN: `count`>0.
  - In DRAIN:
    - `out_valid`=1.
    - `out_data` = word `word_cnt` of the row at `rd_ptr`.
    - `out_tag` = stored tag; `out_idx` = `word_cnt`.
  - On `xfer`:
    - `word_cnt` increments.
    - At `ARRAY_SIZE-1`: `word_cnt` wraps to 0 and `rd_ptr` advances, wrapping.
  - DRAIN→IDLE when `pop` with `count`==1 and no accept.
  - Consecutive rows stream back-to-back with no bubble.
- **Back-pressure:** while `out_valid & ~out_ready`, all `out_*` are held stable.
- **Status outputs:** `out_*` are 0 whenever `out_valid`=0; `row_full` = (`count`==`ROW_DEPTH`); `busy` = (`count`!=0).
- **Arithmetic:** `count` is `$clog2(ROW_DEPTH)+1` bits; pointers are `$clog2(ROW_DEPTH)` bits with natural wrap.

Optional Feature:
- Macro: `ROW_DRAIN_PARITY_EN`.
- Defined:
  - Extra output `out_parity` (1 bit) = XOR-reduce of the word.
  - Parity is computed per word at row accept time and stored alongside the row (`ARRAY_SIZE` bits per entry).
  - `out_parity` is 0 when `out_valid`=0 and is held under back-pressure like `out_data`.
- Undefined: port and parity storage are absent; all other behaviour is identical.

Test Plan:
- **Single row:** reset, one `row_we` with word i = i+1, tag 5, `out_ready`=1 → `out_valid` rises next cycle; 32 words 1..32 on consecutive cycles; `out_idx` 0..31; `out_tag`=5; `out_last` only on word 32; then `busy`=0.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles at word 7 → `out_data`=8 and `out_idx`=7 stable throughout; drain resumes with no word lost or duplicated.
- **Full / overflow:** `out_ready`=0, write rows A, B, C on consecutive cycles (`ROW_DEPTH`=2) → `row_full`=1 after B; C dropped; `overflow`=1 sticky; drain yields A then B only.
- **Write-through-full:** buffer full; `row_we` coincides with the last-word `xfer` of the head row → new row accepted, `count` stays 2, `overflow` stays 0.
- **Mid-drain reset:** `srst`=1 at word 10 of a row → next cycle all outputs 0; a later row drains from word 0.
- **Parity build (`ROW_DRAIN_PARITY_EN`):** words 0x00000001, 0x00000003 → `out_parity` 1, 0.
